// File: rtl/pio_in_user_button_if.sv
// pio_in_user_button_if
// Avalon-MM slave bus bundle for the user push-button input PIO.
//   address    : 2-bit word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
// modport master : CPU / interconnect side
// modport slave  : PIO side
`timescale 1ns/1ps
interface pio_in_user_button_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_user_button.sv
// pio_in_user_button
// Avalon-MM input PIO for the board user push-buttons. Each button line is
// synchronised, debounced, edge-detected into a write-1-to-clear capture
// register, and can raise a maskable level interrupt.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port : raw asynchronous button inputs (active-low buttons)
//   irq     : registered level interrupt request
// Register map (word address, read data zero-extended above WIDTH):
//   0 data (RO, debounced level)   1 reserved (reads 0)
//   2 irq_mask (RW)                3 edge_capture (R/W1C)
`timescale 1ns/1ps
module pio_in_user_button #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  pio_in_user_button_if.slave        bus,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wr_bits;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic             wr_en;
  logic [31:0]      read_mux;

  assign wr_en   = bus.chipselect && !bus.write_n;
  assign wr_bits = WIDTH'(bus.writedata);

  // Two-flop synchroniser; preloaded with the idle button level so that
  // reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
    end else begin
      sync_d <= in_port;
      sync_q <= sync_d;
    end
  end

  // Per-bit debounce: the count restarts whenever the synchronised input
  // agrees with the debounced level, so only an uninterrupted run of
  // DEBOUNCE_CYCLES differing samples moves deb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= RESET_LEVEL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_q[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge selection on the debounced level.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = deb & ~deb_prev;
      1:       edge_det = ~deb & deb_prev;
      default: edge_det = deb ^ deb_prev;
    endcase
  end

  // deb_prev resets to the same level as deb, so reset cannot fake an edge.
  // In the capture update the new detection is OR-ed after the W1C mask,
  // letting a simultaneous edge win over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev     <= RESET_LEVEL;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      deb_prev <= deb;
      if (wr_en && bus.address == 2'd2) irq_mask <= wr_bits;
      if (wr_en && bus.address == 2'd3)
        edge_capture <= (edge_capture & ~wr_bits) | edge_det;
      else
        edge_capture <= edge_capture | edge_det;
      irq <= |(edge_capture & irq_mask);
    end
  end

  always_comb begin
    read_mux = '0;
    case (bus.address)
      2'd0:    read_mux[WIDTH-1:0] = deb;
      2'd2:    read_mux[WIDTH-1:0] = irq_mask;
      2'd3:    read_mux[WIDTH-1:0] = edge_capture;
      default: read_mux = '0;
    endcase
  end

  // Reads have no side effects, so the mux is simply registered every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= read_mux;
  end

endmodule
